mult_div_unit: RTL and testbench

//  Iterative multiply/divide unit in the execute stage, directly downstream of the register file.

---
 rtl/mult_div_if.sv | 26 ++
 rtl/mult_div_unit.sv | 180 ++++++++++++++++++
 tb/tb_mult_div_unit.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_if.sv
// Handshake and result bundle between the execute-stage issue logic and the
// iterative multiply/divide unit.
interface mult_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic             abort;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;

  modport master (
    output start, op, abort, opa, opb,
    input  busy, done, hi, lo, div_zero
  );

  modport slave (
    input  start, op, abort, opa, opb,
    output busy, done, hi, lo, div_zero
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with sign correction applied once at
// the end. Result lands in HI/LO with a fixed latency regardless of operands.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start
// CALC  | one multiply/divide iteration per clock, WIDTH iterations
// FIX   | sign correction and divide-by-zero substitution, write HI/LO
// DONE  | result valid for one cycle; a new start is accepted here too
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      n_rst,
  mult_div_if.slave bus
);

  localparam int            CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             accept, commit;

  logic [CW-1:0]    cnt_q;
  logic             is_div_q;
  logic             neg_res_q;   // negate product (mult) or quotient (div)
  logic             neg_rem_q;   // remainder follows the dividend sign
  logic             dz_q;        // divisor was zero for the latched op
  logic [WIDTH-1:0] raw_a_q;     // unmodified dividend, returned on divide by zero
  logic [WIDTH-1:0] mdr_q;       // multiplicand magnitude or divisor magnitude
  logic [WIDTH-1:0] acc_q;       // product upper half or partial remainder
  logic [WIDTH-1:0] sh_q;        // multiplier/product lower half or dividend/quotient

  logic [WIDTH-1:0] hi_q, lo_q;
  logic             div_zero_q;

  logic             op_div, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  logic [WIDTH:0]   add_sum, rem_sh, trial;
  logic [WIDTH-1:0] acc_step, sh_step;

  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH-1:0]   res_hi, res_lo;

  // Operand decode: op[1] selects divide, op[0] selects signed.
  always_comb begin
    op_div = bus.op[1];
    a_neg  = bus.op[0] & bus.opa[WIDTH-1];
    b_neg  = bus.op[0] & bus.opb[WIDTH-1];
    a_mag  = a_neg ? -bus.opa : bus.opa;
    b_mag  = b_neg ? -bus.opb : bus.opb;
  end

  // One iteration of either shift-add multiply or restoring divide.
  always_comb begin
    add_sum = {1'b0, acc_q} + (sh_q[0] ? {1'b0, mdr_q} : '0);
    rem_sh  = {acc_q, sh_q[WIDTH-1]};
    trial   = rem_sh - {1'b0, mdr_q};
    if (is_div_q) begin
      acc_step = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
      sh_step  = {sh_q[WIDTH-2:0], ~trial[WIDTH]};
    end else begin
      acc_step = add_sum[WIDTH:1];
      sh_step  = {add_sum[0], sh_q[WIDTH-1:1]};
    end
  end

  // Final result with sign correction; divide by zero returns the raw dividend.
  always_comb begin
    prod     = {acc_q, sh_q};
    prod_fix = neg_res_q ? -prod : prod;
    quo_fix  = neg_res_q ? -sh_q : sh_q;
    rem_fix  = neg_rem_q ? -acc_q : acc_q;
    if (!is_div_q) begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end else if (dz_q) begin
      res_hi = raw_a_q;
      res_lo = '1;
    end else begin
      res_hi = rem_fix;
      res_lo = quo_fix;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort wins over both iteration and completion.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = S_CALC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (bus.abort)               state_d = S_IDLE;
        else if (cnt_q == LAST_ITER) state_d = S_FIX;
      end
      S_FIX: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          commit  = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: latch magnitudes and sign info on accept, iterate in CALC.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      raw_a_q   <= '0;
      mdr_q     <= '0;
      acc_q     <= '0;
      sh_q      <= '0;
    end else if (accept) begin
      cnt_q     <= '0;
      is_div_q  <= op_div;
      neg_res_q <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
      dz_q      <= op_div & (bus.opb == '0);
      raw_a_q   <= bus.opa;
      acc_q     <= '0;
      mdr_q     <= op_div ? b_mag : a_mag;
      sh_q      <= op_div ? a_mag : b_mag;
    end else if (state_q == S_CALC) begin
      cnt_q <= cnt_q + CW'(1);
      acc_q <= acc_step;
      sh_q  <= sh_step;
    end
  end

  // Architectural HI/LO/div_zero only change when FIX completes.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else if (commit) begin
      hi_q       <= res_hi;
      lo_q       <= res_lo;
      div_zero_q <= is_div_q & dz_q;
    end
  end

  assign bus.busy     = (state_q == S_CALC) || (state_q == S_FIX);
  assign bus.done     = (state_q == S_DONE);
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed vector table, hand-built abort/ignored
// start/reset sequences, and random operations against an arithmetic model.
module tb_mult_div_unit;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic clk;
  logic n_rst;
  int   checks;
  int   errors;

  mult_div_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural definitions.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el, output logic edz);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    edz = 1'b0;
    eh  = '0;
    el  = '0;
    case (o)
      2'b00: begin
        p  = {32'b0, a} * {32'b0, b};
        eh = p[63:32];
        el = p[31:0];
      end
      2'b01: begin
        p  = 64'(sa * sb);
        eh = p[63:32];
        el = p[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          eh  = a;
          el  = 32'hFFFF_FFFF;
          edz = 1'b1;
        end else if (o == 2'b10) begin
          el = a / b;
          eh = a % b;
        end else begin
          q  = sa / sb;
          r  = sa % sb;
          el = 32'(q);
          eh = 32'(r);
        end
      end
    endcase
  endfunction

  // Issue one op starting now (current cycle), then run until done or budget.
  // inj: cycle index at which a competing start is pulsed; ab: cycle index for abort.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int inj, input int ab, output int lat, output int busy_cnt);
    bus.start = 1'b1;
    bus.op    = o;
    bus.opa   = a;
    bus.opb   = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.opa   = $urandom;
    bus.opb   = $urandom;
    bus.op    = 2'($urandom_range(0, 3));
    lat       = -1;
    busy_cnt  = 0;
    for (int i = 1; i <= 100; i++) begin
      if (bus.busy) busy_cnt++;
      bus.start = (i == inj);
      bus.abort = (i == ab);
      if (i == inj) begin
        bus.op  = 2'b10;
        bus.opa = 32'd100;
        bus.opb = 32'd100;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic check_result(input string tag, input logic [31:0] eh, input logic [31:0] el,
                              input logic edz);
    chk({tag, " hi"}, 64'(bus.hi), 64'(eh));
    chk({tag, " lo"}, 64'(bus.lo), 64'(el));
    chk({tag, " div_zero"}, 64'(bus.div_zero), 64'(edz));
  endtask

  initial begin
    int          lat, bc;
    logic [31:0] eh, el, ra, rb;
    logic        edz;
    logic [1:0]  ro;
    int          sel;

    checks    = 0;
    errors    = 0;
    clk       = 1'b0;
    n_rst     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.abort = 1'b0;
    bus.opa   = '0;
    bus.opb   = '0;

    vecs[0]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1]  = '{2'b01, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[2]  = '{2'b01, 32'h7FFF_FFFF, 32'd2,         32'h0000_0000, 32'hFFFF_FFFE, 1'b0};
    vecs[3]  = '{2'b10, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vecs[4]  = '{2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[5]  = '{2'b11, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
    vecs[6]  = '{2'b11, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1};
    vecs[7]  = '{2'b10, 32'd9,         32'd3,         32'd0,         32'd3,         1'b0};
    vecs[8]  = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};
    vecs[9]  = '{2'b10, 32'hDEAD_BEEF, 32'd0,         32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b1};
    vecs[10] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[11] = '{2'b00, 32'd0,         32'h1234_5678, 32'd0,         32'd0,         1'b0};

    // Reset state
    #1 n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    check_result("reset", 32'd0, 32'd0, 1'b0);
    n_rst = 1'b1;
    @(posedge clk); #1;

    // Directed vector table
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, 0, lat, bc);
      chk($sformatf("vec%0d latency", i), 64'(lat), 64'(LAT));
      chk($sformatf("vec%0d busy cycles", i), 64'(bc), 64'(LAT));
      check_result($sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo, vecs[i].dz);
      @(posedge clk); #1;
      chk($sformatf("vec%0d done pulse width", i), 64'(bus.done), 64'd0);
      chk($sformatf("vec%0d lo held", i), 64'(bus.lo), 64'(vecs[i].lo));
    end

    // Back-to-back: second start issued in the DONE cycle of the first
    run_op(2'b01, 32'hFFFF_FFFD, 32'd7, 0, 0, lat, bc);
    check_result("b2b first", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op(2'b01, 32'h7FFF_FFFF, 32'd2, 0, 0, lat, bc);
    chk("b2b second latency", 64'(lat), 64'(LAT));
    check_result("b2b second", 32'd0, 32'hFFFF_FFFE, 1'b0);

    // Randomized operations against the arithmetic model
    for (int n = 0; n < 300; n++) begin
      ro  = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 7);
      ra  = (sel == 0) ? 32'h8000_0000 : (sel == 1) ? 32'd0 : $urandom;
      sel = $urandom_range(0, 7);
      rb  = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(1, 15)) :
            (sel == 2) ? 32'hFFFF_FFFF : $urandom;
      model(ro, ra, rb, eh, el, edz);
      run_op(ro, ra, rb, 0, 0, lat, bc);
      chk($sformatf("rand%0d op%0d latency", n, ro), 64'(lat), 64'(LAT));
      check_result($sformatf("rand%0d op%0d a=%h b=%h", n, ro, ra, rb), eh, el, edz);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;

    // Start pulsed mid-calculation is ignored
    run_op(2'b00, 32'd6, 32'd7, 5, 0, lat, bc);
    chk("ignored start latency", 64'(lat), 64'(LAT));
    check_result("ignored start", 32'd0, 32'd42, 1'b0);
    @(posedge clk); #1;

    // Abort during CALC: no done, result registers untouched
    run_op(2'b00, 32'd6, 32'd9, 0, 10, lat, bc);
    chk("abort calc no done", 64'(lat), -64'sd1);
    chk("abort calc busy", 64'(bus.busy), 64'd0);
    check_result("abort calc", 32'd0, 32'd42, 1'b0);

    // Abort in the FIX cycle beats completion
    run_op(2'b11, 32'd100, 32'd0, 0, LAT, lat, bc);
    chk("abort fix no done", 64'(lat), -64'sd1);
    chk("abort fix busy", 64'(bus.busy), 64'd0);
    check_result("abort fix", 32'd0, 32'd42, 1'b0);

    // Abort while idle does not block a start
    bus.abort = 1'b1;
    run_op(2'b00, 32'd5, 32'd5, 0, 0, lat, bc);
    chk("idle abort latency", 64'(lat), 64'(LAT));
    check_result("idle abort", 32'd0, 32'd25, 1'b0);
    @(posedge clk); #1;

    // Asynchronous reset mid-CALC clears everything immediately
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.opa   = 32'hFFFF_FFFF;
    bus.opb   = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #3 n_rst = 1'b0;
    #1;
    chk("mid reset busy", 64'(bus.busy), 64'd0);
    chk("mid reset done", 64'(bus.done), 64'd0);
    check_result("mid reset", 32'd0, 32'd0, 1'b0);
    @(posedge clk); #1;
    n_rst = 1'b1;
    @(posedge clk); #1;
    chk("post reset busy", 64'(bus.busy), 64'd0);

    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, lat, bc);
    chk("post reset latency", 64'(lat), 64'(LAT));
    check_result("post reset", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
